// File: rtl/alu_div_seq_if.sv
// alu_div_seq_if: request/response bundle of the sequential divider.
//
// Handshake: a request transfers on a rising edge where REQ_VALID and
// REQ_READY are both high. A response transfers on a rising edge where
// RESULT_VALID and RESULT_READY are both high. The producer holds VALID
// and its payload stable until the transfer edge. BUSY is status only.
interface alu_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic [4:0]       SELECT;
    logic             RESULT_VALID;
    logic             RESULT_READY;
    logic [WIDTH-1:0] RESULT;
    logic             BUSY;

    // Requester / result consumer side.
    modport master (
        output REQ_VALID, DATA1, DATA2, SELECT, RESULT_READY,
        input  REQ_READY, RESULT_VALID, RESULT, BUSY
    );

    // Divider side.
    modport slave (
        input  REQ_VALID, DATA1, DATA2, SELECT, RESULT_READY,
        output REQ_READY, RESULT_VALID, RESULT, BUSY
    );
endinterface

// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// SELECT = {func3, func7[5], func7[0]}. Operands are reduced to magnitudes at
// accept, WIDTH restoring steps run in CALC, signs and special cases are
// applied in FIX, and the result is held in DONE until taken.
// Optional build macro: ALU_DIV_EARLY_OUT_EN -- divide-by-zero, overflow,
// invalid op and |divisor| > |dividend| bypass CALC (same RESULT values).
module alu_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RESETN,
    alu_div_seq_if.slave       bus,
    output logic [1:0]         o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;     // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_data1;    // original dividend, for REM by zero
    logic             r_is_rem;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_dz;
    logic             r_ovf;
    logic             r_inv;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;

    // Request decode: all four ops have func3[2]=1, func7[5]=0, func7[0]=1.
    logic             w_op_valid;
    logic             w_signed;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic             w_dz;
    logic             w_ovf;
    logic             w_skip_calc;
    logic             w_small;

    assign w_op_valid = bus.SELECT[4] & ~bus.SELECT[1] & bus.SELECT[0];
    assign w_signed   = w_op_valid & ~bus.SELECT[2];
    assign w_mag1     = (w_signed && bus.DATA1[WIDTH-1]) ? -bus.DATA1 : bus.DATA1;
    assign w_mag2     = (w_signed && bus.DATA2[WIDTH-1]) ? -bus.DATA2 : bus.DATA2;
    assign w_dz       = (bus.DATA2 == '0);
    assign w_ovf      = w_signed && (bus.DATA1 == MIN_NEG) && (bus.DATA2 == '1);

`ifdef ALU_DIV_EARLY_OUT_EN
    // Divisor larger than dividend: quotient 0, remainder is the dividend.
    assign w_small     = (w_mag2 > w_mag1);
    assign w_skip_calc = ~w_op_valid | w_dz | w_ovf | w_small;
`else
    assign w_small     = 1'b0;
    assign w_skip_calc = ~w_op_valid;
`endif

    // One restoring step: shift {rem, quot} left, trial-subtract the divisor.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div};
    assign w_fits  = ~w_trial[WIDTH];

    // Final value selection, in priority order.
    logic [WIDTH-1:0] w_q_signed;
    logic [WIDTH-1:0] w_r_signed;
    logic [WIDTH-1:0] w_final;

    assign w_q_signed = r_qsign ? -r_quot : r_quot;
    assign w_r_signed = r_rsign ? -r_rem  : r_rem;

    always_comb begin
        w_final = '0;
        if (r_inv)
            w_final = '0;
        else if (r_dz)
            w_final = r_is_rem ? r_data1 : '1;
        else if (r_ovf)
            w_final = r_is_rem ? '0 : MIN_NEG;
        else
            w_final = r_is_rem ? w_r_signed : w_q_signed;
    end

    assign bus.REQ_READY    = (r_state == S_IDLE) && RESETN;
    assign bus.RESULT_VALID = r_valid;
    assign bus.RESULT       = r_result;
    assign bus.BUSY         = (r_state != S_IDLE);
    assign o_dbg_state      = r_state;

    // Control FSM and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_data1  <= '0;
            r_is_rem <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.REQ_VALID) begin
                        r_is_rem <= bus.SELECT[3];
                        r_inv    <= ~w_op_valid;
                        r_dz     <= w_dz;
                        r_ovf    <= w_ovf;
                        r_qsign  <= w_signed & (bus.DATA1[WIDTH-1] ^ bus.DATA2[WIDTH-1]);
                        r_rsign  <= w_signed & bus.DATA1[WIDTH-1];
                        r_data1  <= bus.DATA1;
                        r_div    <= w_mag2;
                        r_cnt    <= '0;
                        if (w_small) begin
                            r_quot <= '0;
                            r_rem  <= w_mag1;
                        end else begin
                            r_quot <= w_mag1;
                            r_rem  <= '0;
                        end
                        r_state  <= w_skip_calc ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem  <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quot <= {r_quot[WIDTH-2:0], w_fits};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_final;
                    r_valid  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (bus.RESULT_READY) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: self-checking bench for alu_div_seq (WIDTH=32).
// Expected results are pushed to exp_q at the accept edge and popped when
// the result handshake happens.
module tb_alu_div_seq;
    localparam int W = 32;
    localparam logic [4:0] OP_DIV  = 5'b10001;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b11001;
    localparam logic [4:0] OP_REMU = 5'b11101;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // Clock and DUT.
    always #5 CLK = ~CLK;

    alu_div_seq_if #(.WIDTH(W)) bus ();

    alu_div_seq #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model of the four ops, with RISC-V special cases.
    function automatic logic [W-1:0] model_result(input logic [4:0] sel, input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
        longint sa, sb, q, r;
        bit     is_rem, is_sgn;
        if (!(sel == OP_DIV || sel == OP_DIVU || sel == OP_REM || sel == OP_REMU))
            return '0;
        is_rem = (sel == OP_REM || sel == OP_REMU);
        is_sgn = (sel == OP_DIV || sel == OP_REM);
        if (b == 0)
            return is_rem ? a : '1;
        if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'h0 : 32'h8000_0000;
        if (is_sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return is_rem ? r[W-1:0] : q[W-1:0];
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic int model_latency(input logic [4:0] sel, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        bit valid_op;
        valid_op = (sel == OP_DIV || sel == OP_DIVU || sel == OP_REM || sel == OP_REMU);
        if (!valid_op)
            return 1;
`ifdef ALU_DIV_EARLY_OUT_EN
        begin
            bit is_sgn;
            logic [W-1:0] ma, mb;
            is_sgn = (sel == OP_DIV || sel == OP_REM);
            ma = (is_sgn && a[W-1]) ? -a : a;
            mb = (is_sgn && b[W-1]) ? -b : b;
            if (b == 0 || (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || mb > ma)
                return 1;
        end
`endif
        return W + 1;
    endfunction

    // Driver: issue one request, check latency/BUSY, backpressure, result.
    task automatic run_op(input string tag, input logic [4:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        int lat;
        bit seen;
        @(negedge CLK);
        check_eq({tag, "_req_ready"}, W'(bus.REQ_READY), 1);
        bus.REQ_VALID = 1'b1;
        bus.SELECT    = sel;
        bus.DATA1     = a;
        bus.DATA2     = b;
        @(posedge CLK);
        exp_q.push_back(model_result(sel, a, b));
        #1;
        bus.REQ_VALID = 1'b0;
        bus.DATA1     = $urandom;
        bus.DATA2     = $urandom;
        bus.SELECT    = 5'($urandom_range(0, 31));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
            check_eq({tag, "_busy"}, W'(bus.BUSY), 1);
            if (bus.RESULT_VALID)
                seen = 1'b1;
        end
        check_eq({tag, "_latency"}, W'(lat), W'(model_latency(sel, a, b)));
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            check_eq({tag, "_hold_result"}, bus.RESULT, exp_q[0]);
            check_eq({tag, "_hold_valid"}, W'(bus.RESULT_VALID), 1);
            check_eq({tag, "_hold_req_ready"}, W'(bus.REQ_READY), 0);
        end
        @(negedge CLK);
        bus.RESULT_READY = 1'b1;
        check_eq({tag, "_result"}, bus.RESULT, exp_q.pop_front());
        @(posedge CLK);
        #1;
        bus.RESULT_READY = 1'b0;
        check_eq({tag, "_valid_clear"}, W'(bus.RESULT_VALID), 0);
        check_eq({tag, "_req_ready_after"}, W'(bus.REQ_READY), 1);
        check_eq({tag, "_busy_after"}, W'(bus.BUSY), 0);
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    // Main sequence.
    initial begin
        bus.REQ_VALID    = 1'b0;
        bus.RESULT_READY = 1'b0;
        bus.DATA1        = '0;
        bus.DATA2        = '0;
        bus.SELECT       = '0;
        RESETN           = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_result", bus.RESULT, 0);
        check_eq("rst_valid", W'(bus.RESULT_VALID), 0);
        check_eq("rst_busy", W'(bus.BUSY), 0);
        check_eq("rst_req_ready", W'(bus.REQ_READY), 0);
        check_eq("rst_state", W'(dbg_state), 0);
        @(negedge CLK);
        RESETN = 1'b1;

        run_op("div_100_7",  OP_DIV,  32'd100, 32'd7, 0);
        run_op("rem_100_7",  OP_REM,  32'd100, 32'd7, 0);
        run_op("div_neg",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_neg",    OP_REM,  32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_big",   OP_DIVU, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("remu_big",   OP_REMU, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_dz",    OP_DIVU, 32'd5, 32'd0, 0);
        run_op("remu_dz",    OP_REMU, 32'd5, 32'd0, 0);
        run_op("div_dz",     OP_DIV,  32'hFFFF_FFF9, 32'd0, 0);
        run_op("rem_dz",     OP_REM,  32'hFFFF_FFF9, 32'd0, 0);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_bp",     OP_DIV,  32'd1234567, 32'hFFFF_FFF3, 10);
        run_op("divu_b2b",   OP_DIVU, 32'hDEAD_BEEF, 32'd3, 0);
        run_op("div_small",  OP_DIV,  32'd3, 32'd7, 0);
        run_op("rem_small",  OP_REM,  32'hFFFF_FFFD, 32'd7, 0);
        run_op("inv_zero",   5'b00000, 32'd123, 32'd4, 0);
        run_op("inv_bit1",   5'b10011, 32'd123, 32'd4, 2);

        for (int i = 0; i < 8; i++) begin
            logic [4:0]   sel;
            logic [W-1:0] a, b;
            case ($urandom_range(0, 3))
                0:       sel = OP_DIV;
                1:       sel = OP_DIVU;
                2:       sel = OP_REM;
                default: sel = OP_REMU;
            endcase
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
            if ($urandom_range(0, 1) == 1)
                b = -b;
            run_op("rand", sel, a, b, $urandom_range(0, 3));
        end

        run_op("pre_rst", OP_DIVU, 32'd77, 32'd7, 0);

        // Abort an operation during its 10th CALC cycle.
        @(negedge CLK);
        bus.REQ_VALID = 1'b1;
        bus.SELECT    = OP_DIV;
        bus.DATA1     = 32'h1234_5678;
        bus.DATA2     = 32'd3;
        @(posedge CLK);
        #1;
        bus.REQ_VALID = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b0;
        #1;
        check_eq("midrst_req_ready_low", W'(bus.REQ_READY), 0);
        @(posedge CLK);
        #1;
        check_eq("midrst_state", W'(dbg_state), 0);
        check_eq("midrst_result", bus.RESULT, 0);
        check_eq("midrst_valid", W'(bus.RESULT_VALID), 0);
        check_eq("midrst_busy", W'(bus.BUSY), 0);
        @(negedge CLK);
        RESETN = 1'b1;

        run_op("post_rst", OP_DIVU, 32'd1000, 32'd10, 0);

        check_eq("queue_empty", W'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Multi-cycle radix-2 divider, the iterative counterpart of the single-cycle ALU.
- Executes the M-extension divide/remainder ops DIV, DIVU, REM and REMU over a valid/ready request/response handshake.
- Takes the same SELECT encoding as the ALU: func3 in bits 4:2, func7[5] in bit 1, func7[0] in bit 0.
- Sits beside the ALU in the execute stage; the stall logic holds the pipeline while BUSY is high.

Parameters:
WIDTH, 32, operand/result width; iteration count.

Ports:
CLK  input  1  clock, all state updates on rising edge
RESETN  input  1  synchronous active-low reset
REQ_VALID  input  1  request valid
REQ_READY  output  1  unit can accept a request
DATA1  input  WIDTH  dividend
DATA2  input  WIDTH  divisor
SELECT  input  5  op: 10001 DIV, 10101 DIVU, 11001 REM, 11101 REMU
RESULT_VALID  output  1  RESULT holds a completed result
RESULT_READY  input  1  consumer takes result
RESULT  output  WIDTH  quotient or remainder
BUSY  output  1  high in CALC/FIX/DONE

Behaviour:
- Reset (RESETN low at an edge):
  - state goes to IDLE; RESULT=0, RESULT_VALID=0, BUSY=0.
  - REQ_READY is forced 0 while RESETN is low.
  - Reset mid-operation aborts the operation with no result.
- States IDLE, CALC, FIX, DONE. REQ_READY = (state==IDLE) && RESETN.
- Accept: REQ_VALID && REQ_READY at an edge. At that edge, latch:
  - op;
  - |DATA1| and |DATA2|: magnitudes for signed ops, raw values for unsigned ops;
  - quotient sign = DATA1[msb]^DATA2[msb] (signed only);
  - remainder sign = DATA1[msb] (signed only);
  - special-case flags:
    - divide-by-zero: DATA2==0;
    - signed overflow: DIV/REM with DATA1=100..0 and DATA2=all-ones.
  - Then go to CALC with the iteration counter at 0.
- SELECT values outside the four ops are accepted and go straight to FIX; they yield RESULT=0.
- CALC: one restoring step per cycle.
  - Shift the {rem, quot} pair left by one and trial-subtract the divisor.
  - Keep the difference if it is non-negative and set the quotient LSB.
  - After the step with counter = WIDTH-1, go to FIX.
  - CALC lasts exactly WIDTH cycles.
- FIX: one cycle. Register RESULT in priority order:
  1. invalid op → 0;
  2. divide-by-zero → DIV/DIVU all-ones, REM/REMU = original DATA1;
  3. overflow → DIV = 100..0, REM = 0;
  4. otherwise quotient/remainder, negated if the latched sign is set (truncation toward zero).
  - Set RESULT_VALID=1 and go to DONE.
- Latency: RESULT_VALID is high WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
- DONE: RESULT and RESULT_VALID are held stable while RESULT_READY is low.
  - At the edge where RESULT_READY is high: clear RESULT_VALID, go to IDLE.
  - RESULT keeps its last value in IDLE.
  - No same-cycle accept; the next request can be accepted one cycle after the result handshake.
- Inputs are ignored outside IDLE. DATA1/DATA2 changes after accept have no effect.
- All arithmetic is WIDTH-bit modulo. Negating 100..0 yields 100..0.

Optional Feature:
ALU_DIV_EARLY_OUT_EN
- Defined: at accept, these cases skip CALC and go directly to FIX, so RESULT_VALID is high 1 cycle after accept:
  - divide-by-zero;
  - overflow;
  - invalid op;
  - |DATA2| > |DATA1|, which gives quotient 0 and remainder = DATA1.
- Undefined: all valid ops take the full WIDTH+1 latency; special cases are resolved in FIX with identical values.
- RESULT values are identical in both builds.

Test Plan:
- DIV 100/7 → RESULT=14 exactly 33 cycles after accept; REM 100/7 → 2; BUSY high for the whole interval.
- Sign handling:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD;
  - REM same operands → 0xFFFFFFFF;
  - DIVU same operands → 0x7FFFFFFC;
  - REMU same operands → 1.
- Divide-by-zero: DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0xFFFFFFF9/0 → 0xFFFFFFFF; REM 0xFFFFFFF9/0 → 0xFFFFFFF9. Latency is 33 cycles, or 1 cycle with the macro defined.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Backpressure:
  - hold RESULT_READY low 10 cycles after RESULT_VALID → RESULT constant, REQ_READY=0;
  - raise RESULT_READY → RESULT_VALID=0 and REQ_READY=1 the next cycle;
  - back-to-back request accepted then.
- Reset mid-op:
  - RESETN low during the 10th CALC cycle → next edge: IDLE, RESULT=0, RESULT_VALID=0, BUSY=0;
  - subsequent DIVU 1000/10 → 100.
